// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath constants: mux select encodings and datapath width.
package lc3_pkg;

    localparam int unsigned WIDTH = 16;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_BUS  = 2'b01,
        PC_ADDR = 2'b10,
        PC_HOLD = 2'b11
    } pcmux_e;

    typedef enum logic [1:0] {
        A2_ZERO  = 2'b00,
        A2_OFF6  = 2'b01,
        A2_OFF9  = 2'b10,
        A2_OFF11 = 2'b11
    } addr2mux_e;

    localparam logic A1_PC   = 1'b0;
    localparam logic A1_SR1  = 1'b1;
    localparam logic MM_SUM  = 1'b0;
    localparam logic MM_TRAP = 1'b1;

endpackage

// File: rtl/pc_addr_unit_if.sv
// Control/bus signals of the LC-3 IR/PC/MAR address stage.
interface pc_addr_unit_if #(
    parameter int unsigned WIDTH = lc3_pkg::WIDTH
);
    logic [WIDTH-1:0] Bus;
    logic [WIDTH-1:0] SR1_OUT;
    logic             LD_IR;
    logic             LD_PC;
    logic             LD_MAR;
    logic [1:0]       PCMUX;
    logic             ADDR1MUX;
    logic [1:0]       ADDR2MUX;
    logic             MARMUX;
    logic [WIDTH-1:0] IR;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] MAR;
    logic [WIDTH-1:0] ADDR_SUM;
    logic [WIDTH-1:0] MARMUX_Out;
    logic [WIDTH-1:0] IMM5;

    modport master (
        output Bus, SR1_OUT, LD_IR, LD_PC, LD_MAR, PCMUX, ADDR1MUX, ADDR2MUX, MARMUX,
        input  IR, PC, MAR, ADDR_SUM, MARMUX_Out, IMM5
    );

    modport slave (
        input  Bus, SR1_OUT, LD_IR, LD_PC, LD_MAR, PCMUX, ADDR1MUX, ADDR2MUX, MARMUX,
        output IR, PC, MAR, ADDR_SUM, MARMUX_Out, IMM5
    );
endinterface

// File: rtl/addr_gen.sv
// ADDR1/ADDR2 muxes and the effective-address adder; wraps silently modulo 2^WIDTH.
module addr_gen
    import lc3_pkg::*;
#(
    parameter int unsigned AW = lc3_pkg::WIDTH
) (
    input  logic [AW-1:0] i_pc,
    input  logic [AW-1:0] i_sr1,
    input  logic          i_addr1_sel,
    input  logic [1:0]    i_addr2_sel,
    input  logic [AW-1:0] i_off6,
    input  logic [AW-1:0] i_off9,
    input  logic [AW-1:0] i_off11,
    output logic [AW-1:0] o_sum
);
    logic [AW-1:0] w_addr1;
    logic [AW-1:0] w_addr2;

    always_comb begin
        w_addr1 = (i_addr1_sel == A1_SR1) ? i_sr1 : i_pc;
        w_addr2 = '0;
        unique case (i_addr2_sel)
            A2_ZERO:  w_addr2 = '0;
            A2_OFF6:  w_addr2 = i_off6;
            A2_OFF9:  w_addr2 = i_off9;
            A2_OFF11: w_addr2 = i_off11;
            default:  w_addr2 = '0;
        endcase
    end

    assign o_sum = w_addr1 + w_addr2;
endmodule

// File: rtl/sext.sv
// Sign-extends an IN_W-bit field to OUT_W bits by replicating its top bit.
module sext #(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_in,
    output logic [OUT_W-1:0] o_out
);
    assign o_out = {{(OUT_W - IN_W){i_in[IN_W-1]}}, i_in};
endmodule

// File: rtl/pc_addr_unit.sv
// LC-3 IR/PC/MAR registers with PCMUX/MARMUX and effective-address generation.
module pc_addr_unit #(
    parameter int unsigned       WIDTH    = lc3_pkg::WIDTH,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic          Clk,
    input  logic          Reset_n,
    pc_addr_unit_if.slave bus_if
);
    import lc3_pkg::*;

    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_mar;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_off6;
    logic [WIDTH-1:0] w_off9;
    logic [WIDTH-1:0] w_off11;
    logic [WIDTH-1:0] w_imm5;
    logic [WIDTH-1:0] w_trapvect;

    sext #(.IN_W(6),  .OUT_W(WIDTH)) u_sext_off6  (.i_in(r_ir[5:0]),  .o_out(w_off6));
    sext #(.IN_W(9),  .OUT_W(WIDTH)) u_sext_off9  (.i_in(r_ir[8:0]),  .o_out(w_off9));
    sext #(.IN_W(11), .OUT_W(WIDTH)) u_sext_off11 (.i_in(r_ir[10:0]), .o_out(w_off11));
    sext #(.IN_W(5),  .OUT_W(WIDTH)) u_sext_imm5  (.i_in(r_ir[4:0]),  .o_out(w_imm5));

    addr_gen #(.AW(WIDTH)) u_addr_gen (
        .i_pc        (r_pc),
        .i_sr1       (bus_if.SR1_OUT),
        .i_addr1_sel (bus_if.ADDR1MUX),
        .i_addr2_sel (bus_if.ADDR2MUX),
        .i_off6      (w_off6),
        .i_off9      (w_off9),
        .i_off11     (w_off11),
        .o_sum       (w_sum)
    );

    assign w_trapvect = {{(WIDTH - 8){1'b0}}, r_ir[7:0]};

    always_comb begin
        w_pc_next = r_pc;
        unique case (bus_if.PCMUX)
            PC_INC:  w_pc_next = r_pc + 1'b1;
            PC_BUS:  w_pc_next = bus_if.Bus;
            PC_ADDR: w_pc_next = w_sum;
            PC_HOLD: w_pc_next = r_pc;
            default: w_pc_next = r_pc;
        endcase
    end

    // Sum is built from pre-edge IR/PC, so a same-cycle LD_IR only affects the next address.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_ir  <= '0;
            r_pc  <= PC_RESET;
            r_mar <= '0;
        end else begin
            if (bus_if.LD_IR)  r_ir  <= bus_if.Bus;
            if (bus_if.LD_PC)  r_pc  <= w_pc_next;
            if (bus_if.LD_MAR) r_mar <= bus_if.Bus;
        end
    end

    assign bus_if.IR         = r_ir;
    assign bus_if.PC         = r_pc;
    assign bus_if.MAR        = r_mar;
    assign bus_if.ADDR_SUM   = w_sum;
    assign bus_if.MARMUX_Out = (bus_if.MARMUX == MM_TRAP) ? w_trapvect : w_sum;
    assign bus_if.IMM5       = w_imm5;
endmodule

// File: tb/tb_pc_addr_unit.sv
// Directed and randomized checks of pc_addr_unit against an arithmetic reference model.
module tb_pc_addr_unit;
    logic Clk;
    logic Reset_n;
    int   tests;
    int   fails;

    logic [15:0] m_ir;
    logic [15:0] m_pc;
    logic [15:0] m_mar;

    pc_addr_unit_if #(.WIDTH(16)) bif ();

    pc_addr_unit #(.WIDTH(16), .PC_RESET(16'h0000)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus_if  (bif)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
        logic signed [15:0] t;
        t = v << (16 - bits);
        return 16'(t >>> (16 - bits));
    endfunction

    function automatic logic [15:0] ref_sum();
        logic [15:0] a1;
        logic [15:0] a2;
        a1 = bif.ADDR1MUX ? bif.SR1_OUT : m_pc;
        case (bif.ADDR2MUX)
            2'd0:    a2 = 16'h0000;
            2'd1:    a2 = sx(m_ir, 6);
            2'd2:    a2 = sx(m_ir, 9);
            default: a2 = sx(m_ir, 11);
        endcase
        return a1 + a2;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven; check combinational outputs, clock once, check registers.
    task automatic step(input bit do_comb);
        logic [15:0] sum;
        logic [15:0] n_ir;
        logic [15:0] n_pc;
        logic [15:0] n_mar;
        #1;
        sum = ref_sum();
        if (do_comb) begin
            chk("addr_sum", bif.ADDR_SUM, sum);
            chk("marmux_out", bif.MARMUX_Out, bif.MARMUX ? {8'h00, m_ir[7:0]} : sum);
            chk("imm5", bif.IMM5, sx(m_ir, 5));
        end
        n_ir = m_ir;
        n_pc = m_pc;
        n_mar = m_mar;
        if (!Reset_n) begin
            n_ir = 16'h0000;
            n_pc = 16'h0000;
            n_mar = 16'h0000;
        end else begin
            if (bif.LD_IR) n_ir = bif.Bus;
            if (bif.LD_MAR) n_mar = bif.Bus;
            if (bif.LD_PC) begin
                case (bif.PCMUX)
                    2'd0:    n_pc = m_pc + 16'd1;
                    2'd1:    n_pc = bif.Bus;
                    2'd2:    n_pc = sum;
                    default: n_pc = m_pc;
                endcase
            end
        end
        @(posedge Clk);
        m_ir = n_ir;
        m_pc = n_pc;
        m_mar = n_mar;
        #1;
        chk("ir", bif.IR, m_ir);
        chk("pc", bif.PC, m_pc);
        chk("mar", bif.MAR, m_mar);
    endtask

    task automatic idle();
        Reset_n = 1'b1;
        bif.LD_IR = 1'b0;
        bif.LD_PC = 1'b0;
        bif.LD_MAR = 1'b0;
        bif.PCMUX = 2'b11;
        bif.ADDR1MUX = 1'b0;
        bif.ADDR2MUX = 2'b00;
        bif.MARMUX = 1'b0;
        bif.SR1_OUT = 16'h0000;
        bif.Bus = 16'h0000;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_ir = 16'hxxxx;
        m_pc = 16'hxxxx;
        m_mar = 16'hxxxx;

        // Reset dominates a same-cycle PC load
        idle();
        Reset_n = 1'b0;
        bif.LD_PC = 1'b1;
        bif.PCMUX = 2'b01;
        bif.Bus = 16'h1234;
        step(1'b0);
        chk("rst_pc", bif.PC, 16'h0000);
        chk("rst_ir", bif.IR, 16'h0000);
        chk("rst_mar", bif.MAR, 16'h0000);
        idle();
        #1;
        chk("rst_sum", bif.ADDR_SUM, 16'h0000);
        chk("rst_imm5", bif.IMM5, 16'h0000);

        // BRnzp offset9 = -1 from 3005
        idle(); bif.LD_PC = 1'b1; bif.PCMUX = 2'b01; bif.Bus = 16'h3005; step(1'b1);
        idle(); bif.LD_IR = 1'b1; bif.Bus = 16'h0FFF; step(1'b1);
        idle(); bif.LD_PC = 1'b1; bif.PCMUX = 2'b10; bif.ADDR2MUX = 2'b10; step(1'b1);
        chk("br_pc", bif.PC, 16'h3004);

        // LDR with negative offset6 wrapping below zero
        idle(); bif.LD_IR = 1'b1; bif.Bus = 16'h6060; step(1'b1);
        idle(); bif.SR1_OUT = 16'h0010; bif.ADDR1MUX = 1'b1; bif.ADDR2MUX = 2'b01;
        #1;
        chk("ldr_sum", bif.ADDR_SUM, 16'hFFF0);
        bif.Bus = ref_sum(); bif.LD_MAR = 1'b1; step(1'b1);
        chk("ldr_mar", bif.MAR, 16'hFFF0);

        // JSR offset11 = -1024
        idle(); bif.LD_PC = 1'b1; bif.PCMUX = 2'b01; bif.Bus = 16'h3000; step(1'b1);
        idle(); bif.LD_IR = 1'b1; bif.Bus = 16'h4C00; step(1'b1);
        idle(); bif.LD_PC = 1'b1; bif.PCMUX = 2'b10; bif.ADDR2MUX = 2'b11; step(1'b1);
        chk("jsr_pc", bif.PC, 16'h2C00);

        // TRAP vector and IMM5
        idle(); bif.LD_IR = 1'b1; bif.Bus = 16'hF025; step(1'b1);
        idle(); bif.MARMUX = 1'b1; #1;
        chk("trap_vec", bif.MARMUX_Out, 16'h0025);
        idle(); bif.LD_IR = 1'b1; bif.Bus = 16'h1030; step(1'b1);
        idle(); #1;
        chk("imm5_neg", bif.IMM5, 16'hFFF0);

        // PC wrap, reserved hold, and same-cycle IR+PC load
        idle(); bif.LD_PC = 1'b1; bif.PCMUX = 2'b01; bif.Bus = 16'hFFFF; step(1'b1);
        idle(); bif.LD_PC = 1'b1; bif.PCMUX = 2'b00; step(1'b1);
        chk("pc_wrap", bif.PC, 16'h0000);
        idle(); bif.LD_PC = 1'b1; bif.PCMUX = 2'b11; bif.Bus = 16'hABCD; step(1'b1);
        chk("pc_hold", bif.PC, 16'h0000);
        // IR is 1030 (offset9 = 0x030); new IR 01FF must not affect this sum
        idle(); bif.LD_IR = 1'b1; bif.LD_PC = 1'b1; bif.PCMUX = 2'b10;
        bif.ADDR2MUX = 2'b10; bif.Bus = 16'h01FF; step(1'b1);
        chk("old_ir_pc", bif.PC, 16'h0030);
        chk("new_ir", bif.IR, 16'h01FF);

        // Randomized traffic including occasional mid-sequence resets
        for (int i = 0; i < 300; i++) begin
            Reset_n = ($urandom_range(0, 15) != 0);
            bif.LD_IR = 1'($urandom);
            bif.LD_PC = 1'($urandom);
            bif.LD_MAR = 1'($urandom);
            bif.PCMUX = 2'($urandom);
            bif.ADDR1MUX = 1'($urandom);
            bif.ADDR2MUX = 2'($urandom);
            bif.MARMUX = 1'($urandom);
            bif.SR1_OUT = 16'($urandom);
            bif.Bus = 16'($urandom);
            step(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
